// File: rtl/sm_dsp_pkg.sv
// Shared sign-magnitude types and arithmetic for the DSP adder scheduler.
// SM_SCHED_SATURATE_EN: clamp the magnitude on same-sign carry-out instead of wrapping.
package sm_dsp_pkg;

  localparam int DATA_W   = 12;
  localparam int MAG_W    = DATA_W - 1;
  localparam int SIGN_BIT = DATA_W - 1;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_word_t;

  typedef struct packed {
    logic     ovf;
    sm_word_t word;
  } sm_result_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  function automatic sm_result_t sm_add(input sm_word_t a, input sm_word_t b);
    sm_result_t     r;
    logic [MAG_W:0] sum;
    r   = '0;
    sum = {1'b0, a.mag} + {1'b0, b.mag};
    if (a.sign == b.sign) begin
      r.ovf       = sum[MAG_W];
      r.word.sign = a.sign;
`ifdef SM_SCHED_SATURATE_EN
      r.word.mag  = sum[MAG_W] ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
`else
      r.word.mag  = sum[MAG_W-1:0];
`endif
    end else if (a.mag > b.mag) begin
      r.word.sign = a.sign;
      r.word.mag  = a.mag - b.mag;
    end else if (b.mag > a.mag) begin
      r.word.sign = b.sign;
      r.word.mag  = b.mag - a.mag;
    end
    // Equal magnitudes with opposite signs fall through to +0.
    return r;
  endfunction

endpackage

// File: rtl/sm_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around;
// the pointer moves just past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    // NOTE: every output gets a default first so no path leaves a latch behind.
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_i[idx[ID_W-1:0]]) begin
        found                     = 1'b1;
        grant_o[idx[ID_W-1:0]]    = 1'b1;
        grant_idx_o               = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i)
      ptr_d = (grant_idx_o == ID_W'(NUM_REQ-1)) ? '0 : grant_idx_o + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sm_add_scheduler.sv
// Shares one sign-magnitude adder among NUM_REQ requesters through a one-entry
// result register. SM_SCHED_SATURATE_EN selects saturating overflow.
module sm_add_scheduler
  import sm_dsp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_ovf
);

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               slot_free;
  logic               accept;
  sm_word_t           op_a, op_b;
  sm_result_t         sum;
  sm_word_t           data_q;
  logic [ID_W-1:0]    id_q;
  logic               ovf_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // The slot can take a new pair when empty or when its result leaves this cycle.
  assign slot_free = (state_q == EMPTY) || res_ready;
  assign req_ready = grant & {NUM_REQ{slot_free}};
  assign accept    = |(req_valid & req_ready);

  assign op_a = req_a[grant_idx*DATA_W +: DATA_W];
  assign op_b = req_b[grant_idx*DATA_W +: DATA_W];
  assign sum  = sm_add(op_a, op_b);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (res_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= sum.word;
        id_q   <= grant_idx;
        ovf_q  <= sum.ovf;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_ovf   = ovf_q;

endmodule

// File: doc/sm_add_scheduler.md
Name: sm_add_scheduler

Overview:
Shares one 12-bit sign-magnitude add/subtract datapath among NUM_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the result is registered with the winning requester's ID. It sits between the DSP filter/accumulate stages and the single shared adder resource of the core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 12, operand/result width; bit DATA_W-1 = sign, bits DATA_W-2:0 = magnitude
ID_W, 2, width of res_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_a  in  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
res_valid  out  1  result register holds an unconsumed result
res_ready  in  1  downstream accepts the result
res_data  out  DATA_W  sign-magnitude sum
res_id  out  ID_W  index of the requester that produced res_data
res_ovf  out  1  magnitude carry-out occurred (same-sign add only)

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): res_valid=0, res_data=0, res_id=0, res_ovf=0, rr pointer=0, FSM=EMPTY. Reset mid-transaction drops the result; nothing is replayed.
- FSM states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on res_ready with no new accept.
  - FULL -> FULL on res_ready with a simultaneous accept (back-to-back; no bubble).
  - FULL with res_ready=0: outputs held stable and req_ready all 0.
- Grant: combinational round-robin over req_valid, starting search at pointer, ascending index with wrap-around.
- req_ready[g] = grant[g] & (FSM==EMPTY | res_ready).
- Accept = req_valid[g] & req_ready[g]. On accept, pointer <= (g+1) mod NUM_REQ. Without an accept, pointer holds.
- Latency: 1 cycle. Operands accepted at edge N appear on res_data/res_id/res_ovf after edge N, with res_valid=1.
- Throughput: 1 result/cycle while res_ready=1.
- Requester rule: once req_valid is asserted, it and its operands stay stable until accepted. The bench flags violations.
- Arithmetic (m = magnitude, s = sign):
  - sa==sb: m = (ma+mb) mod 2^(DATA_W-1); s = sa; res_ovf = carry out of the magnitude add.
  - sa!=sb and ma>mb: m = ma-mb, s = sa.
  - sa!=sb and mb>ma: m = mb-ma, s = sb.
  - sa!=sb and ma==mb: result is +0 (s=0, m=0).
  - -0 + -0 yields -0 (s=1, m=0). +0 + -0 yields +0.
  - res_ovf=0 for any opposite-sign operation.
- Simultaneous requests: exactly one grant per cycle. Every continuously valid requester is served within NUM_REQ accepts.
- No requests: req_ready all 0, pointer unchanged.

Optional Feature:
SM_SCHED_SATURATE_EN
- Defined: on same-sign carry-out, magnitude saturates to 2^(DATA_W-1)-1 (0x7FF at default), sign preserved, res_ovf=1.
- Undefined: magnitude wraps modulo 2^(DATA_W-1), res_ovf=1.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package sm_dsp_pkg:
  - DATA_W, MAG_W (=DATA_W-1), SIGN_BIT constants.
  - typedef sm_word_t (sign + magnitude struct).
  - enum sched_state_t {EMPTY, FULL}.
  - Function sm_add returning {ovf, sm_word_t}, used by both RTL and the bench model.
- Natural sub-module: rr_arbiter (NUM_REQ, ID_W). Inputs: request vector, pointer, advance enable. Outputs: one-hot grant, encoded index. Owns the pointer register.

Test Plan:
- Reset then single request: req0 a=0x005 (+5), b=0x803 (-3), res_ready=1 -> req_ready[0] same cycle; next cycle res_valid=1, res_data=0x002, res_id=0, res_ovf=0.
- Equal magnitudes, opposite signs: a=0x80A, b=0x00A -> res_data=0x000. Also a=0x800, b=0x800 -> res_data=0x800.
- Overflow: a=0x7FF, b=0x001 -> res_ovf=1; res_data=0x000 (wrap) or 0x7FF (SM_SCHED_SATURATE_EN).
- All four requesters continuously valid, res_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; one result per cycle, res_id matches.
- Backpressure: res_ready=0 for 3 cycles while FULL with req1,req2 valid -> req_ready=0, res_* stable; on res_ready=1, req1 accepted the same cycle with no bubble.
- Async reset asserted mid-stream while FULL -> res_valid=0 immediately (no clock needed), pointer=0; after release, req3 and req0 both valid -> req0 granted first.
